led_bank_scheduler: RTL

Shares the board's 8-LED bank between up to NUM_REQ pattern requesters using round-robin arbitration. A granted requester's 8-bit pattern is latched and displayed for a fixed number of prescaler ticks. The bank then returns to idle for re-arbitration. Sits between application blocks that want to show status patterns and the top-level LED pins; it owns the 50 MHz-derived tick that all LED timing uses.

---
 rtl/led_sched_pkg.sv | 14 +
 rtl/led_prescaler.sv | 24 ++
 rtl/led_bank_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED bank scheduler.
// Optional feature macro: LED_HEARTBEAT_IDLE_EN (idle heartbeat on LED[0]).
package led_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } sched_state_e;

  localparam int          LED_W            = 8;
  localparam logic [31:0] DEFAULT_PRESCALE = 32'h000F_FFFF;
  localparam logic [LED_W-1:0] IDLE_PATTERN = 8'h00;

endpackage

// File: rtl/led_prescaler.sv
// Free-running tick prescaler: counts 0..PRESCALE, tick while at the terminal value.
module led_prescaler
  import led_sched_pkg::*;
#(
  parameter logic [31:0] PRESCALE = DEFAULT_PRESCALE
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  logic [31:0] r_cnt;
  logic        w_term;

  assign w_term = (r_cnt == PRESCALE);
  assign o_tick = w_term;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_cnt <= '0;
    else if (w_term) r_cnt <= '0;
    else             r_cnt <= r_cnt + 32'd1;
  end

endmodule

// File: rtl/led_bank_scheduler.sv
// Round-robin sharing of the 8-LED bank; a granted pattern is held for HOLD_TICKS ticks.
// Define LED_HEARTBEAT_IDLE_EN to blink LED[0] on every tick while idle.
module led_bank_scheduler
  import led_sched_pkg::*;
#(
  parameter int          NUM_REQ    = 4,
  parameter logic [31:0] PRESCALE   = DEFAULT_PRESCALE,
  parameter int          HOLD_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [LED_W*NUM_REQ-1:0] pattern,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     done,
  output logic                     busy,
  output logic [LED_W-1:0]         LED
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int HC_W  = $clog2(HOLD_TICKS + 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_TICKS - 1);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};

  sched_state_e       r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [HC_W-1:0]    r_hold;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_busy;
  logic [LED_W-1:0]   r_led;

  logic               w_tick;
  logic               w_any;
  logic [PTR_W-1:0]   w_pick;
  logic [PTR_W-1:0]   w_idx;
  logic [LED_W-1:0]   w_pat [NUM_REQ];
  logic [LED_W-1:0]   w_idle_led;
  logic               w_done;
  logic               w_abort;

  led_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_tick (w_tick)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pat
    assign w_pat[g] = pattern[g*LED_W +: LED_W];
  end

  // Scan from farthest to nearest so the first requester after r_ptr wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_ptr;
    w_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      if (req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  // A requester dropping on the final tick still counts as a completed hold.
  assign w_done  = (r_state == SHOW) && w_tick && (r_hold == HOLD_LAST);
  assign w_abort = (r_state == SHOW) && !req[r_ptr];

`ifdef LED_HEARTBEAT_IDLE_EN
  logic r_hb;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hb <= 1'b0;
    else     r_hb <= r_hb ^ w_tick;
  end
  assign w_idle_led = {{(LED_W-1){1'b0}}, r_hb ^ w_tick};
`else
  assign w_idle_led = IDLE_PATTERN;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= PTR_RST;
      r_hold  <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_led   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= SHOW;
            r_ptr   <= w_pick;
            r_hold  <= '0;
            r_grant <= ONE << w_pick;
            r_busy  <= 1'b1;
            r_led   <= w_pat[w_pick];
          end else begin
            r_led   <= w_idle_led;
          end
        end
        SHOW: begin
          if (w_done || w_abort) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_led   <= w_idle_led;
          end else if (w_tick) begin
            r_hold  <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;
  assign LED   = r_led;
  assign done  = w_done;

endmodule
